// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if -- instruction-memory and decoder-side signals of the
// fetch sequencer.
//   imem_req / imem_addr   : read request and address (sequencer -> memory)
//   imem_ack / imem_rdata  : read data valid strobe and word (memory -> sequencer)
//   instr / instr_pc       : registered instruction and its address (-> decoder)
//   instr_valid            : instr / instr_pc hold a live instruction
//   stall                  : decoder is not accepting instr this cycle
// master = sequencer side, slave = memory/decoder side.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        stall;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, stall
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, stall
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- sequential instruction fetch with stall, redirect and
// halt control. Issues one read per cycle at the current PC while in FETCH,
// registers the returned word for the decoder and counts accepted fetches.
//
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   start             : leave IDLE/HALT and begin fetching
//   halt              : stop fetching (wins over start)
//   redirect          : load redirect_pc (word aligned) and squash held instr
//   redirect_pc       : redirect target
//   bus (master)      : imem request/response and decoder handshake
//   state             : IDLE=0, FETCH=1, STALL=2, HALT=3
//   fetch_count       : saturating count of accepted fetches
//
// Build option: define REDIRECT_BUBBLE_EN to insert one idle request cycle
// after every redirect.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    fetch_sequencer_if.master    bus,
    output logic [1:0]           state,
    output logic [COUNT_W-1:0]   fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc;
    logic [31:0] target;
    logic        accept;
    logic        held;
    logic        active;

    // Masking keeps every bit of redirect_pc in use while forcing alignment.
    assign target = redirect_pc & 32'hFFFF_FFFC;
    assign held   = bus.instr_valid && bus.stall;
    assign active = (state_q == S_FETCH) || (state_q == S_STALL);
    assign accept = bus.imem_req && bus.imem_ack;
    assign state  = state_q;

`ifdef REDIRECT_BUBBLE_EN
    // High for exactly the cycle following a redirect edge.
    logic bubble;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bubble <= 1'b0;
        else       bubble <= redirect;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: redirect > halt > normal flow in FETCH/STALL;
    // in IDLE/HALT a redirect only moves the PC and halt beats start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: if (!halt && start) state_d = S_FETCH;
            S_FETCH: begin
                if (redirect)  state_d = S_FETCH;
                else if (halt) state_d = S_HALT;
                else if (held) state_d = S_STALL;
            end
            S_STALL: begin
                if (redirect)       state_d = S_FETCH;
                else if (halt)      state_d = S_HALT;
                else if (!bus.stall) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: no request while a held instruction is blocked.
    always_comb begin
        bus.imem_addr = pc;
`ifdef REDIRECT_BUBBLE_EN
        bus.imem_req  = (state_q == S_FETCH) && !held && !bubble;
`else
        bus.imem_req  = (state_q == S_FETCH) && !held;
`endif
    end

    // Datapath: PC, instruction register and fetch counter.
    // Redirect and halt take precedence over a same-cycle ack, which is
    // simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc              <= RESET_PC;
            bus.instr       <= 32'h0;
            bus.instr_pc    <= 32'h0;
            bus.instr_valid <= 1'b0;
            fetch_count     <= '0;
        end else if (redirect) begin
            pc              <= target;
            bus.instr_valid <= 1'b0;
        end else if (active && halt) begin
            bus.instr_valid <= 1'b0;
        end else if (accept) begin
            bus.instr       <= bus.imem_rdata;
            bus.instr_pc    <= pc;
            bus.instr_valid <= 1'b1;
            pc              <= pc + 32'd4;
            if (fetch_count != '1) fetch_count <= fetch_count + COUNT_W'(1);
        end else if (bus.instr_valid && !bus.stall) begin
            bus.instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, halt, redirect;
    logic [31:0]   redirect_pc;
    logic [1:0]    state;
    logic [CW-1:0] fetch_count;

    fetch_sequencer_if bus();

    fetch_sequencer #(.RESET_PC(32'h0), .COUNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt       (halt),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .bus        (bus),
        .state      (state),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    // Reference model: architectural view of the sequencer.
    localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, STALL = 2'd2, HALT = 2'd3;
    logic [1:0]    m_st;
    logic [31:0]   m_pc, m_instr, m_ipc;
    logic          m_v, m_bub;
    logic [CW-1:0] m_cnt;

    function automatic logic m_req(input logic stall_i);
        return (m_st == FETCH) && !(m_v && stall_i) && !m_bub;
    endfunction

    task automatic model_reset();
        m_st = IDLE; m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
        m_v = 1'b0; m_bub = 1'b0; m_cnt = '0;
    endtask

    // Apply the rules for one rising edge using the current inputs.
    task automatic model_edge();
        logic acc;
        logic blocked;
        logic [31:0] tgt;
        acc     = m_req(bus.stall) && bus.imem_ack;
        blocked = m_v && bus.stall;
        tgt     = {redirect_pc[31:2], 2'b00};
`ifdef REDIRECT_BUBBLE_EN
        m_bub   = redirect;
`endif
        if (m_st == IDLE || m_st == HALT) begin
            if (redirect) m_pc = tgt;
            if (start && !halt) m_st = FETCH;
        end else if (redirect) begin
            m_pc = tgt; m_v = 1'b0; m_st = FETCH;
        end else if (halt) begin
            m_st = HALT; m_v = 1'b0;
        end else begin
            if (acc) begin
                m_instr = bus.imem_rdata; m_ipc = m_pc; m_v = 1'b1;
                m_pc = m_pc + 32'd4;
                if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
            end else if (m_v && !bus.stall) begin
                m_v = 1'b0;
            end
            if (m_st == FETCH && blocked) m_st = STALL;
            else if (m_st == STALL && !bus.stall) m_st = FETCH;
        end
    endtask

    task automatic check_outputs();
        chk("state",       32'(state),           32'(m_st));
        chk("imem_req",    32'(bus.imem_req),    32'(m_req(bus.stall)));
        chk("imem_addr",   bus.imem_addr,        m_pc);
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_v));
        chk("instr",       bus.instr,            m_instr);
        chk("instr_pc",    bus.instr_pc,         m_ipc);
        chk("fetch_count", 32'(fetch_count),     32'(m_cnt));
    endtask

    // Called at a falling edge: drive, check, advance model, step one clock.
    task automatic cycle(input logic st_i, input logic hl_i, input logic rd_i,
                         input logic [31:0] rpc_i, input logic sl_i,
                         input logic ak_i, input logic [31:0] data_i);
        start = st_i; halt = hl_i; redirect = rd_i; redirect_pc = rpc_i;
        bus.stall = sl_i; bus.imem_ack = ak_i; bus.imem_rdata = data_i;
        #1;
        check_outputs();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        bus.stall = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic sequential fetch
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 32'hA);
        cycle(0, 0, 0, 0, 0, 1, 32'hB);
        chk("t035.addr",  bus.imem_addr, 32'h8);
        chk("t035.ipc",   bus.instr_pc,  32'h4);
        chk("t035.instr", bus.instr,     32'hB);
        chk("t035.count", 32'(fetch_count), 32'd2);

        // Stall holds the instruction
        repeat (3) cycle(0, 0, 0, 0, 1, 1, 32'hBAD);
        chk("t036.state", 32'(state),        32'd2);
        chk("t036.req",   32'(bus.imem_req), 32'd0);
        chk("t036.instr", bus.instr,         32'hB);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("t036.resume", 32'(state), 32'd1);

        // Redirect with a same-cycle ack
        cycle(0, 0, 0, 0, 0, 1, 32'hC);
        cycle(0, 0, 1, 32'h103, 0, 1, 32'hD);
        chk("t037.addr",  bus.imem_addr,       32'h100);
        chk("t037.valid", 32'(bus.instr_valid), 32'd0);
        chk("t037.count", 32'(fetch_count),    32'd3);
`ifdef REDIRECT_BUBBLE_EN
        chk("t037.bubble", 32'(bus.imem_req), 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("t037.req",  32'(bus.imem_req), 32'd1);
        chk("t037.addr2", bus.imem_addr,    32'h100);
`else
        chk("t037.req", 32'(bus.imem_req), 32'd1);
`endif

        // PC wrap
        cycle(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 32'hDEAD);
        chk("t038.ipc",  bus.instr_pc,  32'hFFFF_FFFC);
        chk("t038.addr", bus.imem_addr, 32'h0);

        // Halt with a same-cycle ack, then restart at the same pc
        cycle(0, 1, 0, 0, 0, 1, 32'hE);
        chk("t039.state", 32'(state),           32'd3);
        chk("t039.valid", 32'(bus.instr_valid), 32'd0);
        chk("t039.count", 32'(fetch_count),     32'd4);
        cycle(1, 1, 0, 0, 0, 0, 0);
        chk("t039.halt_wins", 32'(state), 32'd3);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("t039.state2", 32'(state),    32'd1);
        chk("t039.addr",   bus.imem_addr, 32'h0);

        // Counter saturation
        repeat (12) cycle(0, 0, 0, 0, 0, 1, $urandom);
        chk("sat.count", 32'(fetch_count), 32'hF);

        // Asynchronous reset between edges, ack ignored while held
        start = 1'b0; bus.stall = 1'b0; bus.imem_ack = 1'b1;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t040.state", 32'(state),           32'd0);
        chk("t040.count", 32'(fetch_count),     32'd0);
        chk("t040.valid", 32'(bus.instr_valid), 32'd0);
        chk("t040.addr",  bus.imem_addr,        32'h0);
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 0, 0, 0, 0, 1, 32'h77);
        chk("t040.ignored", 32'(fetch_count), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 19) == 0, $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 7, $urandom);
        end
        #1;
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
